// File: rtl/pe_datapath_responder.sv
// Datapath responder for the PE controller: fetches DEPTH word pairs, XNOR-popcounts,
// accumulates a saturating signed dot product and residual-binarizes it over LEVELS gammas.
module pe_datapath_responder #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 16,
  parameter int LEVELS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    is_read,
  input  logic                    add_pcnts,
  input  logic                    continue_pcnt,
  input  logic                    continue_acc,
  input  logic                    is_count,
  input  logic                    binarize_start,
  input  logic                    finish,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [WORD_W-1:0]       act_rdata,
  input  logic [WORD_W-1:0]       wgt_rdata,
  input  logic [LEVELS*ACC_W-1:0] gamma,
  output logic                    ready_to_pick,
  output logic                    pcnt_done,
  output logic                    acc_done,
  output logic                    cnt_done,
  output logic                    read_done,
  output logic                    finish_all,
  output logic [LEVELS-1:0]       out_bits,
  output logic                    out_valid,
  output logic                    proto_err
);
  localparam int PC_W  = $clog2(WORD_W + 1);
  localparam int LV_W  = $clog2(LEVELS + 1);
  localparam int SUM_W = ACC_W + PC_W + 2;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) <<< (ACC_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {BIN_IDLE, BIN_STEP, BIN_DONE} binState_t;

  binState_t state, nextState;

  logic [ADDR_W:0]          wordCnt, wordCntInc;
  logic                     readPend, cpPrev;
  logic [WORD_W-1:0]        dataR;
  logic [PC_W-1:0]          pcnt, pcntNext;
  logic signed [ACC_W-1:0]  acc, accNext, residual, resNext;
  logic signed [SUM_W-1:0]  accSum, resSum, gammaExt;
  logic [ACC_W-1:0]         gammaSel;
  logic [LV_W-1:0]          lvlCnt;
  logic readyToPickR, pcntDoneR, accDoneR, cntDoneR, readDoneR, protoErrR;
  logic [LEVELS-1:0]        outBitsR;
  logic readOk, readErr, countOk, countErr, binErr, pcntFirst;
  logic binLoad, binStep, finishAllC;
  logic unusedAddPcnts;

  assign unusedAddPcnts = add_pcnts;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) return ACC_W'(SAT_MAX);
    if (v < SAT_MIN) return ACC_W'(SAT_MIN);
    return ACC_W'(v);
  endfunction

  // finish overrides every strobe; is_count takes priority over a concurrent is_read
  always_comb begin
    wordCntInc = wordCnt + 1'b1;
    readOk    = is_read && !finish && !is_count && !readyToPickR && (wordCnt != DEPTH_C);
    readErr   = is_read && !finish && !readOk;
    countOk   = is_count && !finish && accDoneR;
    countErr  = is_count && !finish && !accDoneR;
    binErr    = binarize_start && !finish && !readDoneR;
    pcntFirst = continue_pcnt && !cpPrev && !finish;
  end

  always_comb begin
    pcntNext = '0;
    for (int unsigned i = 0; i < WORD_W; i++) pcntNext = pcntNext + PC_W'(dataR[i]);
    accSum  = SUM_W'(acc) + (SUM_W'($signed({1'b0, pcnt})) <<< 1) - SUM_W'(WORD_W);
    accNext = sat(accSum);
  end

  always_comb begin
    gammaSel = '0;
    for (int unsigned l = 0; l < LEVELS; l++)
      if (lvlCnt == LV_W'(l)) gammaSel = gamma[l*ACC_W +: ACC_W];
    gammaExt = SUM_W'($signed({1'b0, gammaSel}));
    resSum   = residual[ACC_W-1] ? SUM_W'(residual) + gammaExt : SUM_W'(residual) - gammaExt;
    resNext  = sat(resSum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BIN_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (finish) nextState = BIN_IDLE;
    else begin
      case (state)
        BIN_IDLE: if (binarize_start && readDoneR) nextState = BIN_STEP;
        BIN_STEP: if (binarize_start && lvlCnt == LV_W'(LEVELS - 1)) nextState = BIN_DONE;
        BIN_DONE: nextState = BIN_DONE;
        default:  nextState = BIN_IDLE;
      endcase
    end
  end

  always_comb begin
    binLoad    = (state == BIN_IDLE) && (nextState == BIN_STEP);
    binStep    = (state == BIN_STEP) && binarize_start && !finish;
    finishAllC = (state == BIN_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCnt <= '0; readPend <= 1'b0; cpPrev <= 1'b0; dataR <= '0; pcnt <= '0;
      acc <= '0; residual <= '0; lvlCnt <= '0; outBitsR <= '0;
      readyToPickR <= 1'b0; pcntDoneR <= 1'b0; accDoneR <= 1'b0;
      cntDoneR <= 1'b0; readDoneR <= 1'b0;
    end else if (finish) begin
      wordCnt <= '0; readPend <= 1'b0; cpPrev <= continue_pcnt; pcnt <= '0;
      acc <= '0; residual <= '0; lvlCnt <= '0;
      readyToPickR <= 1'b0; pcntDoneR <= 1'b0; accDoneR <= 1'b0;
      cntDoneR <= 1'b0; readDoneR <= 1'b0;
    end else begin
      cpPrev    <= continue_pcnt;
      readPend  <= readOk;
      pcntDoneR <= pcntFirst;
      if (readOk) cntDoneR <= 1'b0;
      if (readPend) begin
        dataR        <= ~(act_rdata ^ wgt_rdata);
        readyToPickR <= 1'b1;
      end
      if (pcntFirst) begin
        pcnt         <= pcntNext;
        readyToPickR <= 1'b0;
      end
      if (continue_acc) begin
        acc      <= accNext;
        accDoneR <= 1'b1;
      end
      if (countOk) begin
        accDoneR <= 1'b0;
        wordCnt  <= wordCntInc;
        if (wordCntInc == DEPTH_C) readDoneR <= 1'b1;
        else                       cntDoneR  <= 1'b1;
      end
      if (binLoad) begin
        residual <= acc;
        lvlCnt   <= '0;
      end
      if (binStep) begin
        for (int unsigned l = 0; l < LEVELS; l++)
          if (lvlCnt == LV_W'(l)) outBitsR[l] <= !residual[ACC_W-1];
        residual <= resNext;
        lvlCnt   <= lvlCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              protoErrR <= 1'b0;
    else if (readErr || countErr || binErr) protoErrR <= 1'b1;
  end

  assign mem_en        = readOk;
  assign mem_addr      = wordCnt[ADDR_W-1:0];
  assign ready_to_pick = readyToPickR;
  assign pcnt_done     = pcntDoneR;
  assign acc_done      = accDoneR;
  assign cnt_done      = cntDoneR;
  assign read_done     = readDoneR;
  assign finish_all    = finishAllC;
  assign out_bits      = outBitsR;
  assign out_valid     = finish;
  assign proto_err     = protoErrR;
endmodule

// File: tb/tb_pe_datapath_responder.sv
// Scoreboard bench: three responders (DEPTH16/ACC16, DEPTH16/ACC8, DEPTH1/ACC16) driven
// by a directed controller model; out_bits checked by a monitor on out_valid.
module tb_pe_datapath_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] isRead = '0, addPcnts = '0, contPcnt = '0, contAcc = '0;
  logic [2:0] isCount = '0, binStart = '0, fin = '0;
  logic [2:0] memEn, readyToPick, pcntDone, accDone, cntDone, readDone, finishAll, outValid, protoErr;
  logic [3:0]  memAddr [3];
  logic [1:0]  outBits [3];
  logic [31:0] actR [3];
  logic [31:0] wgtR [3];
  logic [31:0] actMem [16];
  logic [31:0] wgtMem [16];
  logic [31:0] gammaA = '0, gammaC = '0;
  logic [15:0] gammaB = '0;

  typedef struct packed { logic [1:0] dut; logic [1:0] bits; } exp_t;
  exp_t expQ[$];
  exp_t monE;
  int nVec = 0, nBad = 0, nPushed = 0, nSeen = 0;

  always @(posedge clk)
    for (int d = 0; d < 3; d++)
      if (memEn[d]) begin
        actR[d] <= actMem[memAddr[d]];
        wgtR[d] <= wgtMem[memAddr[d]];
      end

  pe_datapath_responder #(.WORD_W(32), .DEPTH(16), .ADDR_W(4), .ACC_W(16), .LEVELS(2)) dutA (
    .clk(clk), .rst(rst), .is_read(isRead[0]), .add_pcnts(addPcnts[0]),
    .continue_pcnt(contPcnt[0]), .continue_acc(contAcc[0]), .is_count(isCount[0]),
    .binarize_start(binStart[0]), .finish(fin[0]), .mem_en(memEn[0]), .mem_addr(memAddr[0]),
    .act_rdata(actR[0]), .wgt_rdata(wgtR[0]), .gamma(gammaA), .ready_to_pick(readyToPick[0]),
    .pcnt_done(pcntDone[0]), .acc_done(accDone[0]), .cnt_done(cntDone[0]), .read_done(readDone[0]),
    .finish_all(finishAll[0]), .out_bits(outBits[0]), .out_valid(outValid[0]), .proto_err(protoErr[0]));

  pe_datapath_responder #(.WORD_W(32), .DEPTH(16), .ADDR_W(4), .ACC_W(8), .LEVELS(2)) dutB (
    .clk(clk), .rst(rst), .is_read(isRead[1]), .add_pcnts(addPcnts[1]),
    .continue_pcnt(contPcnt[1]), .continue_acc(contAcc[1]), .is_count(isCount[1]),
    .binarize_start(binStart[1]), .finish(fin[1]), .mem_en(memEn[1]), .mem_addr(memAddr[1]),
    .act_rdata(actR[1]), .wgt_rdata(wgtR[1]), .gamma(gammaB), .ready_to_pick(readyToPick[1]),
    .pcnt_done(pcntDone[1]), .acc_done(accDone[1]), .cnt_done(cntDone[1]), .read_done(readDone[1]),
    .finish_all(finishAll[1]), .out_bits(outBits[1]), .out_valid(outValid[1]), .proto_err(protoErr[1]));

  pe_datapath_responder #(.WORD_W(32), .DEPTH(1), .ADDR_W(4), .ACC_W(16), .LEVELS(2)) dutC (
    .clk(clk), .rst(rst), .is_read(isRead[2]), .add_pcnts(addPcnts[2]),
    .continue_pcnt(contPcnt[2]), .continue_acc(contAcc[2]), .is_count(isCount[2]),
    .binarize_start(binStart[2]), .finish(fin[2]), .mem_en(memEn[2]), .mem_addr(memAddr[2]),
    .act_rdata(actR[2]), .wgt_rdata(wgtR[2]), .gamma(gammaC), .ready_to_pick(readyToPick[2]),
    .pcnt_done(pcntDone[2]), .acc_done(accDone[2]), .cnt_done(cntDone[2]), .read_done(readDone[2]),
    .finish_all(finishAll[2]), .out_bits(outBits[2]), .out_valid(outValid[2]), .proto_err(protoErr[2]));

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (outValid[d]) begin
        nSeen++;
        nVec++;
        if (expQ.size() == 0) begin
          nBad++;
          $display("FAIL out_valid[dut%0d]: unexpected pulse with out_bits=%b, required no pulse", d, outBits[d]);
        end else begin
          monE = expQ.pop_front();
          if (monE.dut != 2'(d) || monE.bits !== outBits[d]) begin
            nBad++;
            $display("FAIL scoreboard[dut%0d]: got out_bits=%b, required dut%0d out_bits=%b",
                     d, outBits[d], monE.dut, monE.bits);
          end
        end
      end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s[dut%0d]: got %0h, required %0h", name, d, got, want);
    end
  endtask

  task automatic checkIdle(input string name, input int d);
    check(name, d, {memEn[d], readyToPick[d], pcntDone[d], accDone[d], cntDone[d], readDone[d],
                    finishAll[d], outValid[d], protoErr[d], outBits[d], memAddr[d]}, 32'h0);
  endtask

  task automatic loadMem(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] aRest,
                         input logic [31:0] w);
    for (int i = 0; i < 16; i++) begin
      actMem[i] = (i == 0) ? a0 : (i == 1) ? a1 : aRest;
      wgtMem[i] = w;
    end
  endtask

  task automatic doWord(input int d, input int w, input int depth);
    isRead[d] = 1'b1; #1;
    check("mem_en", d, memEn[d], 1);
    check("mem_addr", d, memAddr[d], w);
    tick(); isRead[d] = 1'b0;
    check("cnt_done after read", d, cntDone[d], 0);
    check("ready_to_pick early", d, readyToPick[d], 0);
    tick();
    check("ready_to_pick", d, readyToPick[d], 1);
    addPcnts[d] = 1'b1; contPcnt[d] = 1'b1;
    tick();
    check("ready_to_pick cleared", d, readyToPick[d], 0);
    check("pcnt_done", d, pcntDone[d], 1);
    tick(); contPcnt[d] = 1'b0; addPcnts[d] = 1'b0;
    check("pcnt_done pulse", d, pcntDone[d], 0);
    contAcc[d] = 1'b1;
    tick(); contAcc[d] = 1'b0;
    check("acc_done", d, accDone[d], 1);
    tick();
    check("acc_done held", d, accDone[d], 1);
    isCount[d] = 1'b1;
    tick(); isCount[d] = 1'b0;
    check("acc_done cleared", d, accDone[d], 0);
    check("read_done", d, readDone[d], 32'(w == depth - 1));
    check("cnt_done", d, cntDone[d], 32'(w != depth - 1));
  endtask

  task automatic binarizeFinish(input int d, input logic [1:0] bits, input logic expErr);
    exp_t e;
    int k;
    e.dut = 2'(d);
    e.bits = bits;
    expQ.push_back(e);
    nPushed++;
    binStart[d] = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!finishAll[d] && k < 20);
    check("finish_all latency", d, k, 3);
    tick();
    check("finish_all held", d, finishAll[d], 1);
    binStart[d] = 1'b0; fin[d] = 1'b1; #1;
    check("out_valid", d, outValid[d], 1);
    check("out_bits", d, outBits[d], bits);
    tick(); fin[d] = 1'b0;
    check("finish_all cleared", d, finishAll[d], 0);
    check("read_done cleared", d, readDone[d], 0);
    check("out_bits held", d, outBits[d], bits);
    check("proto_err", d, protoErr[d], expErr);
  endtask

  task automatic runNeuron(input int d, input int depth, input logic [1:0] bits);
    for (int w = 0; w < depth; w++) doWord(d, w, depth);
    binarizeFinish(d, bits, 1'b0);
  endtask

  initial begin
    loadMem(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0);
    tick(); tick();
    for (int d = 0; d < 3; d++) checkIdle("reset outputs", d);
    rst = 1'b0;
    tick();

    // zero dot product: 0 -> bit0=1, -4 -> bit1=0
    gammaA = {16'd4, 16'd4};
    runNeuron(0, 16, 2'b01);
    // back-to-back: -32 -8 + 0*14 = -40; -40+50=10 -> 2'b10
    loadMem(32'hFFFFFFFF, 32'h000FFFFF, 32'h0000FFFF, 32'h0);
    gammaA = {16'd20, 16'd50};
    runNeuron(0, 16, 2'b10);
    // 16*32 = 512; 512-600 = -88 -> 2'b01
    loadMem(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    gammaA = {16'd50, 16'd600};
    runNeuron(0, 16, 2'b01);

    // ACC_W=8: +512 clamps to 127; 127-127=0 -> 2'b11
    gammaB = {8'd1, 8'd127};
    runNeuron(1, 16, 2'b11);
    // -512 clamps to -127; -127+127=0 -> 2'b10
    loadMem(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    runNeuron(1, 16, 2'b10);

    // DEPTH=1: 32 -> 16 -> 8, plus is_read after read_done
    loadMem(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    gammaC = {16'd8, 16'd16};
    doWord(2, 0, 1);
    isRead[2] = 1'b1; #1;
    check("mem_en at depth", 2, memEn[2], 0);
    tick(); isRead[2] = 1'b0;
    check("proto_err read at depth", 2, protoErr[2], 1);
    binarizeFinish(2, 2'b11, 1'b1);

    // protocol errors on dutA, then reset mid-accumulate at word 7
    loadMem(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0);
    gammaA = {16'd4, 16'd4};
    isRead[0] = 1'b1; #1;
    check("mem_addr first", 0, memAddr[0], 0);
    tick(); isRead[0] = 1'b0;
    tick();
    check("ready_to_pick before re-read", 0, readyToPick[0], 1);
    isRead[0] = 1'b1; #1;
    check("mem_en on re-read", 0, memEn[0], 0);
    tick(); isRead[0] = 1'b0;
    check("proto_err re-read", 0, protoErr[0], 1);
    isCount[0] = 1'b1;
    tick(); isCount[0] = 1'b0;
    check("acc_done after bad is_count", 0, accDone[0], 0);
    check("cnt_done after bad is_count", 0, cntDone[0], 0);
    contPcnt[0] = 1'b1; tick(); tick(); contPcnt[0] = 1'b0;
    contAcc[0] = 1'b1; tick(); contAcc[0] = 1'b0;
    isCount[0] = 1'b1; tick(); isCount[0] = 1'b0;
    check("cnt_done after word 0", 0, cntDone[0], 1);
    for (int w = 1; w < 7; w++) doWord(0, w, 16);
    isRead[0] = 1'b1; #1;
    check("mem_addr word 7", 0, memAddr[0], 7);
    tick(); isRead[0] = 1'b0;
    tick();
    contPcnt[0] = 1'b1; tick(); tick(); contPcnt[0] = 1'b0;
    contAcc[0] = 1'b1; tick(); contAcc[0] = 1'b0;
    check("acc_done before reset", 0, accDone[0], 1);
    rst = 1'b1; #1;
    checkIdle("async reset outputs", 0);
    tick(); rst = 1'b0;
    tick();
    checkIdle("post reset outputs", 0);
    runNeuron(0, 16, 2'b01);

    tick(); tick();
    check("out_valid count", 0, nSeen, nPushed);
    check("scoreboard drained", 0, expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
